// File: rtl/div_128x64_seq.sv
// Sequential unsigned 128/64 restoring divider, one radix-2 step per cycle.
// Shares the start/done handshake with the 64x64 multiplier it inverts.
module div_128x64_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in_dividend,
    input  logic [63:0]  in_divisor,
    output logic [63:0]  quotient,
    output logic [63:0]  remainder,
    output logic         done,
    output logic         busy,
    output logic         div_zero,
    output logic         overflow
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] prem_q, shreg_q, qacc_q, divisor_q;
    logic        exc_zero_q;
    logic [63:0] quotient_q, remainder_q;
    logic        done_q, busy_q, div_zero_q, overflow_q;

    logic [64:0] t_d, diff_d;
    logic        qbit_d;
    logic [63:0] prem_d, qacc_d;

    // NOTE: combinational logic uses blocking '=' with every output defaulted first,
    // so no latch can be inferred; state below uses non-blocking '<=' only.
    always_comb begin
        t_d    = {prem_q, shreg_q[63]};
        diff_d = t_d - {1'b0, divisor_q};
        // The compare is 65 bits wide so a partial remainder with bit 63 set keeps its carry.
        qbit_d = (t_d >= {1'b0, divisor_q});
        prem_d = qbit_d ? diff_d[63:0] : t_d[63:0];
        qacc_d = {qacc_q[62:0], qbit_d};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            shreg_q     <= '0;
            qacc_q      <= '0;
            divisor_q   <= '0;
            exc_zero_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        divisor_q   <= in_divisor;
                        prem_q      <= in_dividend[127:64];
                        shreg_q     <= in_dividend[63:0];
                        qacc_q      <= '0;
                        cnt_q       <= '0;
                        quotient_q  <= '0;
                        remainder_q <= '0;
                        div_zero_q  <= 1'b0;
                        overflow_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        if (in_divisor == 64'd0) begin
                            exc_zero_q <= 1'b1;
                            state_q    <= FIN;
                        end else if (in_dividend[127:64] >= in_divisor) begin
                            exc_zero_q <= 1'b0;
                            state_q    <= FIN;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem_q  <= prem_d;
                    shreg_q <= {shreg_q[62:0], 1'b0};
                    qacc_q  <= qacc_d;
                    cnt_q   <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        quotient_q  <= qacc_d;
                        remainder_q <= prem_d;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                FIN: begin
                    // FIN lasts two cycles so exceptions report at E0+2.
                    if (cnt_q == 6'd0) begin
                        cnt_q <= 6'd1;
                    end else begin
                        cnt_q       <= '0;
                        quotient_q  <= '1;
                        remainder_q <= exc_zero_q ? shreg_q : 64'd0;
                        div_zero_q  <= exc_zero_q;
                        overflow_q  <= ~exc_zero_q;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_div_128x64_seq.sv
// Scoreboard bench for div_128x64_seq: expectations come from native 128-bit
// arithmetic, are queued at drive time and popped when done is seen.
module tb_div_128x64_seq;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        logic        ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] in_dividend;
    logic [63:0]  in_divisor;
    logic [63:0]  quotient, remainder;
    logic         done, busy, div_zero, overflow;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    div_128x64_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_dividend(in_dividend),
        .in_divisor (in_divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .busy       (busy),
        .div_zero   (div_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [127:0] dvd, input logic [63:0] dvs);
        exp_t         e;
        logic [127:0] qq, rr;
        e = '0;
        if (dvs == 64'd0) begin
            e.q = '1; e.r = dvd[63:0]; e.dz = 1'b1;
        end else if (dvd[127:64] >= dvs) begin
            e.q = '1; e.r = '0; e.ov = 1'b1;
        end else begin
            qq = dvd / {64'd0, dvs};
            rr = dvd % {64'd0, dvs};
            e.q = qq[63:0]; e.r = rr[63:0];
        end
        return e;
    endfunction

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"},  quotient,  e.q);
            check({tag, "_r"},  remainder, e.r);
            check({tag, "_dz"}, div_zero,  e.dz);
            check({tag, "_ov"}, overflow,  e.ov);
        end
    endtask

    // Called just after an edge; counts edges until done is seen (or budget runs out).
    task automatic wait_done(output int lat, input int budget);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // One operation; inj_at injects a start pulse at edge E0+inj_at, rst_at
    // asserts reset at edge E0+rst_at (abort). Negative values disable either.
    task automatic run_op(input string tag, input logic [127:0] dvd, input logic [63:0] dvs,
                          input int inj_at, input int rst_at);
        exp_t e;
        int   lat;
        int   exp_lat;
        int   spurious;
        e = model(dvd, dvs);
        exp_lat = (e.dz || e.ov) ? 2 : 64;
        if (rst_at < 0) sb.push_back(e);
        in_dividend = dvd;
        in_divisor  = dvs;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        in_dividend = {$urandom, $urandom, $urandom, $urandom};
        in_divisor  = {$urandom, $urandom};
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            if (k == inj_at) begin
                start       = 1'b1;
                in_dividend = 128'd5;
                in_divisor  = 64'd1;
            end
            if (k == inj_at + 1) start = 1'b0;
            if (k == rst_at) rst = 1'b0;
            @(posedge clk); #1;
            if (k == 1 && exp_lat > 1) check({tag, "_busy_e1"}, busy, 1'b1);
            if (k == rst_at) begin
                check({tag, "_abort_busy"}, busy, 1'b0);
                check({tag, "_abort_done"}, done, 1'b0);
                rst = 1'b1;
                break;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        if (rst_at >= 0) begin
            spurious = 0;
            for (int k = 0; k < 80; k++) begin
                @(posedge clk); #1;
                if (done) spurious++;
            end
            check({tag, "_abort_no_done"}, spurious, 0);
        end else begin
            check({tag, "_latency"}, lat, exp_lat);
            if (lat >= 0) begin
                check({tag, "_busy_done"}, busy, 1'b0);
                compare_result(tag);
                @(posedge clk); #1;
                check({tag, "_done_pulse"}, done, 1'b0);
                check({tag, "_q_held"}, quotient, e.q);
            end else begin
                void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        logic [63:0]  a, b, hi, lo;
        logic [127:0] prod;
        int           idle_done, lat;
        exp_t         e;

        rst = 1'b0; start = 1'b1; in_dividend = '1; in_divisor = 64'd3;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_outputs", {quotient, remainder, done, busy, div_zero, overflow}, 0);
        end
        rst = 1'b1; start = 1'b0;
        idle_done = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done || busy) idle_done++;
        end
        check("idle_quiet", idle_done, 0);

        run_op("inverse", 128'h3FFFFFFFFFFFFFFF_0000000000000001, 64'h7FFFFFFFFFFFFFFF, -1, -1);
        check("inverse_q_const", quotient, 64'h7FFFFFFFFFFFFFFF);
        run_op("small_fe01", 128'hFE01, 64'hFF, -1, -1);
        check("small_fe01_q_const", quotient, 64'hFF);
        run_op("small_1000_7", 128'd1000, 64'd7, -1, -1);
        check("small_1000_7_r_const", remainder, 64'd6);
        run_op("carry65", 128'h1_0000000000000000, 64'h8000000000000000, -1, -1);
        check("carry65_q_const", quotient, 64'd2);
        run_op("divzero", 128'h1234, 64'd0, -1, -1);
        check("divzero_r_const", remainder, 64'h1234);
        run_op("overflow", {64'd1, 64'd0}, 64'd1, -1, -1);
        check("overflow_flag_const", overflow, 1'b1);

        run_op("inject", 128'h3FFFFFFFFFFFFFFF_0000000000000001, 64'h7FFFFFFFFFFFFFFF, 10, -1);
        run_op("abort", 128'h1_0000000000000000, 64'h8000000000000000, -1, 30);
        run_op("after_abort", 128'd1000, 64'd7, -1, -1);

        // start held high: a new operation is accepted on the edge after done.
        e = model(128'd1000, 64'd7);
        sb.push_back(e); sb.push_back(e);
        in_dividend = 128'd1000; in_divisor = 64'd7; start = 1'b1;
        @(posedge clk); #1;
        wait_done(lat, 200);
        check("b2b_lat1", lat, 64);
        compare_result("b2b_1");
        @(posedge clk); #1;
        check("b2b_accept", busy, 1'b1);
        start = 1'b0;
        wait_done(lat, 200);
        check("b2b_lat2", lat, 64);
        compare_result("b2b_2");

        for (int i = 0; i < 50; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (b == 64'd0) b = 64'd1;
            prod = {64'd0, a} * {64'd0, b};
            sb.push_back('{q: a, r: 64'd0, dz: 1'b0, ov: 1'b0});
            in_dividend = prod; in_divisor = b; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(lat, 200);
            check("rt_lat", lat, 64);
            compare_result("roundtrip");
        end

        for (int i = 0; i < 50; i++) begin
            b = {$urandom, $urandom};
            if (b == 64'd0) b = 64'd9;
            if (i % 4 == 3) b = b >> ($urandom_range(63, 0));
            if (b == 64'd0) b = 64'd1;
            hi = {$urandom, $urandom};
            if (i % 2 == 0) hi = hi % b;
            lo = {$urandom, $urandom};
            e = model({hi, lo}, b);
            sb.push_back(e);
            in_dividend = {hi, lo}; in_divisor = b; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(lat, 200);
            check("rand_lat", lat, e.ov ? 2 : 64);
            if (!e.ov) begin
                check("rand_inv", {64'd0, quotient} * {64'd0, b} + {64'd0, remainder}, {hi, lo});
                check("rand_rem_lt", remainder < b, 1'b1);
            end
            compare_result("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_128x64_seq.md
# div_128x64_seq

Sequential unsigned divider that undoes the 128-bit product of the multiplier: it takes a 128-bit dividend and a 64-bit divisor and returns a 64-bit quotient and a 64-bit remainder. It uses the same single-cycle `start` / pulsed `done` handshake as the multiplier, so both blocks share drivers and benches. It computes one restoring radix-2 step per cycle. Dividing `a*b` by `b` returns `a` with remainder 0.

## Interface
- No parameters; widths are fixed at 128/64.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge).
- `start` in 1: request. Sampled only in IDLE.
- `in_dividend` in 128: dividend, captured on the accepting edge.
- `in_divisor` in 64: divisor, captured on the accepting edge.
- `quotient` out 64: result quotient. Held from `done` until the next accepted `start`.
- `remainder` out 64: result remainder. Held like `quotient`.
- `done` out 1: one-cycle pulse; `quotient`/`remainder`/flags are valid in that cycle.
- `busy` out 1: high from the accepting edge until the edge that raises `done`.
- `div_zero` out 1: last operation had divisor 0. Held with the results.
- `overflow` out 1: last operation's quotient does not fit in 64 bits. Held with the results.

## Operation
- Only the IDLE state accepts `start`.
- States: IDLE, CALC, FIN.
- IDLE, `start`=1 (accepting edge E0):
  - capture the operands;
  - clear `quotient`, `remainder`, `div_zero` and `overflow`;
  - `busy`<=1.
- Classification at E0, in priority order:
  - divisor==0: go to FIN with `div_zero`.
  - dividend[127:64] >= divisor: go to FIN with `overflow`.
  - Otherwise: go to CALC with step counter=0. Initialize the 64-bit partial remainder to dividend[127:64] and the shift register to dividend[63:0].
- CALC, per edge:
  - form t = {partial remainder, MSB of shift register}, 65 bits;
  - shift the shift register left by one;
  - if t >= divisor: partial remainder = t - divisor, quotient bit = 1;
  - otherwise: partial remainder = t[63:0], quotient bit = 0;
  - shift the quotient bit into the quotient LSB.
  - The compare/subtract is 65 bits wide, so a partial remainder with bit 63 set must not lose its carry.
- CALC, step counter==63: perform the final step, load the outputs, `done`<=1, `busy`<=0, go to IDLE.
- FIN, divide-by-zero:
  - `quotient` = all ones, `remainder` = dividend[63:0];
  - `div_zero`=1, `done`<=1, `busy`<=0, go to IDLE.
- FIN, overflow:
  - `quotient` = all ones, `remainder` = 0;
  - `overflow`=1, `done`<=1, `busy`<=0, go to IDLE.
- `start` while `busy`=1: ignored; operands are not re-captured.
- `start` held high in IDLE: a new operation begins every time IDLE is re-entered. The edge after `done` is an accepting edge if `start`=1 then.
- Operands may change freely after E0.
- `quotient` and `remainder` are updated only at the `done` edge; intermediate values are never visible on the outputs.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, counter=0, and every output is 0 (`quotient`, `remainder`, `done`, `busy`, `div_zero`, `overflow`).
  - Reset overrides `start`.
  - Reset mid-CALC aborts the operation; no `done` is produced.
- Normal latency: `done` rises at edge E0+64 and is high for exactly one cycle (E0+64 to E0+65).
- Exception latency: `done` rises at edge E0+2 (E0→FIN, FIN→IDLE with `done`).
- Back-to-back throughput: one operation per 65 cycles in the normal path.
- `busy`=1 in the cycles between E0 and the `done` edge; it is 0 in the `done` cycle.
- Result invariant, normal path: dividend == quotient*divisor + remainder, with remainder < divisor.

## Test plan
- Reset and idle:
  - Stimulus: `rst`=0 for 2 edges with `start`=1.
  - Response: all outputs 0 and no `done`. After `rst`=1 and `start`=0, nothing happens for 100 cycles.
- Exact inverse:
  - Stimulus: dividend 0x3FFFFFFFFFFFFFFF_0000000000000001, divisor 0x7FFFFFFFFFFFFFFF.
  - Response: `quotient`=0x7FFFFFFFFFFFFFFF, `remainder`=0, flags 0, `done` exactly at E0+64.
- Small values:
  - Stimulus 1: 0xFE01 / 0xFF. Response: q=0xFF, r=0.
  - Stimulus 2: 1000 / 7. Response: q=142, r=6.
  - Stimulus 3: 0x01_0000000000000000 (2^64) / 0x80000000_00000000. Response: q=2, r=0. This exercises the 65-bit carry.
- Exceptions:
  - Stimulus 1: divisor 0, dividend 0x1234. Response: `div_zero`=1, q=all ones, r=0x1234, `done` at E0+2.
  - Stimulus 2: dividend[127:64]=1, divisor=1. Response: `overflow`=1, q=all ones, r=0.
- Handshake robustness:
  - Stimulus 1: pulse `start` at E0+10 with different operands. Response: the first operation's results are unaffected.
  - Stimulus 2: `rst`=0 at E0+30. Response: no `done`, `busy`=0 at the next edge, and the next operation is correct.
- Random round-trip:
  - Stimulus: 50 random pairs a, b (b≠0); dividend=a*b, divisor=b.
  - Response: q=a, r=0 for every pair.
  - Also 50 random dividends with random non-zero divisors, checking the result invariant or the `overflow` flag as appropriate.
